// File: rtl/mem_wb_stage_pkg.sv
// Shared bus-width macros and memory-select encodings for the MEM/WB stage
// and any other loader that reuses load_align.
`ifndef BUS_V
`define BUS_V
`define DATA_BUS     31:0
`define ADDR_BUS     31:0
`define REG_ADDR_BUS 4:0
`define MEM_SEL_BUS  3:0
`endif

package mem_wb_stage_pkg;

  localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ACC_BYTE,
    ACC_HALF,
    ACC_WORD,
    ACC_BAD
  } acc_size_e;

  // Any encoding other than the three legal sizes is reported as ACC_BAD,
  // which the aligner treats exactly like a misaligned access.
  function automatic acc_size_e decode_sel(input logic [3:0] sel);
    case (sel)
      MEM_SEL_BYTE: return ACC_BYTE;
      MEM_SEL_HALF: return ACC_HALF;
      MEM_SEL_WORD: return ACC_WORD;
      default:      return ACC_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the byte/half/word lane out of a memory word and
// zero- or sign-extends it; flags misaligned or illegal-size accesses.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_addr,
  input  logic [3:0]        i_sel,
  input  logic              i_sign_ext,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr, 3'b000} +: 8];
  assign w_half = i_word[{i_addr[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_data       = '0;
    o_misaligned = 1'b0;
    case (decode_sel(i_sel))
      ACC_BYTE: o_data = {{(DATA_W-8){i_sign_ext & w_byte[7]}}, w_byte};
      ACC_HALF: begin
        if (i_addr[0]) o_misaligned = 1'b1;
        else           o_data = {{(DATA_W-16){i_sign_ext & w_half[15]}}, w_half};
      end
      ACC_WORD: begin
        if (i_addr != 2'b00) o_misaligned = 1'b1;
        else                 o_data = i_word;
      end
      default:  o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and write-back stage. Define MEM_WB_RETIRE_CNT_EN
// to add the retire_cnt output counting retired non-bubble instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_read_flag_in,
  input  logic                 mem_write_flag_in,
  input  logic                 mem_sign_ext_flag_in,
  input  logic [`MEM_SEL_BUS]  mem_sel_in,
  input  logic [DATA_W-1:0]    result_in,
  input  logic                 reg_write_en_in,
  input  logic [REG_AW-1:0]    reg_write_addr_in,
  input  logic [DATA_W-1:0]    current_pc_addr_in,
  input  logic [DATA_W-1:0]    ram_read_data,
  output logic                 reg_write_en,
  output logic [REG_AW-1:0]    reg_write_addr,
  output logic [DATA_W-1:0]    reg_write_data,
  output logic [DATA_W-1:0]    current_pc_addr_out,
  output logic                 wb_load_flag
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]          retire_cnt
`endif
);

  logic              r_mem_read;
  logic              r_sign_ext;
  logic [3:0]        r_sel;
  logic [DATA_W-1:0] r_result;
  logic              r_reg_we;
  logic [REG_AW-1:0] r_reg_waddr;
  logic [DATA_W-1:0] r_pc;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_data;

  logic              w_stage_moves;
  logic [DATA_W-1:0] w_load_word;
  logic [DATA_W-1:0] w_aligned;
  logic              w_misaligned;
  logic              w_unused_store;

  // Stores never write the register file on their own, so the flag has no
  // consumer in this stage.
  assign w_unused_store = mem_write_flag_in;

  assign w_stage_moves = flush | ~stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read  <= 1'b0;
      r_sign_ext  <= 1'b0;
      r_sel       <= '0;
      r_result    <= '0;
      r_reg_we    <= 1'b0;
      r_reg_waddr <= '0;
      r_pc        <= '0;
    end else if (flush) begin
      r_mem_read  <= 1'b0;
      r_sign_ext  <= 1'b0;
      r_sel       <= '0;
      r_result    <= '0;
      r_reg_we    <= 1'b0;
      r_reg_waddr <= '0;
      r_pc        <= '0;
    end else if (!stall) begin
      r_mem_read  <= mem_read_flag_in;
      r_sign_ext  <= mem_sign_ext_flag_in;
      r_sel       <= mem_sel_in;
      r_result    <= result_in;
      r_reg_we    <= reg_write_en_in;
      r_reg_waddr <= reg_write_addr_in;
      r_pc        <= current_pc_addr_in;
    end
  end

  // The RAM only presents read data for one cycle; the first stalled edge of
  // a load freezes it here so write-back data survives the whole stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_stage_moves) begin
      r_hold_valid <= 1'b0;
    end else if (r_mem_read && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= ram_read_data;
    end
  end

  assign w_load_word = r_hold_valid ? r_hold_data : ram_read_data;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .i_word       (w_load_word),
    .i_addr       (r_result[1:0]),
    .i_sel        (r_sel),
    .i_sign_ext   (r_sign_ext),
    .o_data       (w_aligned),
    .o_misaligned (w_misaligned)
  );

  always_comb begin
    reg_write_data = r_result;
    reg_write_en   = r_reg_we;
    if (r_mem_read) begin
      reg_write_data = w_aligned;
      reg_write_en   = r_reg_we & ~w_misaligned;
    end
    if (r_reg_waddr == '0) reg_write_en = 1'b0;
  end

  assign reg_write_addr      = r_reg_waddr;
  assign current_pc_addr_out = r_pc;
  assign wb_load_flag        = r_mem_read;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // A bubble is recognisable by a zero PC with no register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (!stall && !flush && ((r_pc != '0) || r_reg_we)) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven vectors through a
// scoreboard queue plus stall, flush and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] result_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic [31:0] ram_read_data;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [31:0] current_pc_addr_out;
  logic        wb_load_flag;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] exp_cnt;
  logic [31:0] cnt_before;
  logic        m_nb;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall                (stall),
    .flush                (flush),
    .mem_read_flag_in     (mem_read_flag_in),
    .mem_write_flag_in    (mem_write_flag_in),
    .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
    .mem_sel_in           (mem_sel_in),
    .result_in            (result_in),
    .reg_write_en_in      (reg_write_en_in),
    .reg_write_addr_in    (reg_write_addr_in),
    .current_pc_addr_in   (current_pc_addr_in),
    .ram_read_data        (ram_read_data),
    .reg_write_en         (reg_write_en),
    .reg_write_addr       (reg_write_addr),
    .reg_write_data       (reg_write_data),
    .current_pc_addr_out  (current_pc_addr_out),
    .wb_load_flag         (wb_load_flag)
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    .retire_cnt           (retire_cnt)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sext;
    logic [3:0]  sel;
    logic [31:0] result;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic [31:0] ram;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        load;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic sext,
                              input logic [3:0] sel, input logic [31:0] result,
                              input logic we, input logic [4:0] waddr,
                              input logic [31:0] pc, input logic [31:0] ram,
                              input logic exp_we, input logic [31:0] exp_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sext = sext; v.sel = sel; v.result = result;
    v.we = we; v.waddr = waddr; v.pc = pc; v.ram = ram;
    v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    mem_read_flag_in     = v.rd;
    mem_write_flag_in    = v.wr;
    mem_sign_ext_flag_in = v.sext;
    mem_sel_in           = v.sel;
    result_in            = v.result;
    reg_write_en_in      = v.we;
    reg_write_addr_in    = v.waddr;
    current_pc_addr_in   = v.pc;
  endtask

  // One clock edge; the retire model follows the same edge from the inputs.
  task automatic tick();
`ifdef MEM_WB_RETIRE_CNT_EN
    if (!stall && !flush && m_nb) exp_cnt = exp_cnt + 32'd1;
    if (flush)       m_nb = 1'b0;
    else if (!stall) m_nb = (current_pc_addr_in != 32'd0) || reg_write_en_in;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    vec_t v;

    vecs[0]  = mk(1, 0, 1, 4'b0001, 32'h0000_1003, 1, 5'd5,  32'h100, 32'h80FF_1234, 1, 32'hFFFF_FF80);
    vecs[1]  = mk(1, 0, 0, 4'b0011, 32'h0000_2002, 1, 5'd6,  32'h104, 32'hBEEF_0001, 1, 32'h0000_BEEF);
    vecs[2]  = mk(1, 0, 0, 4'b1111, 32'h0000_2001, 1, 5'd7,  32'h108, 32'h1234_5678, 0, 32'h0000_0000);
    vecs[3]  = mk(0, 0, 0, 4'b0000, 32'hCAFE_F00D, 1, 5'd8,  32'h10C, 32'hFFFF_FFFF, 1, 32'hCAFE_F00D);
    vecs[4]  = mk(0, 0, 0, 4'b0000, 32'h0000_0077, 1, 5'd0,  32'h110, 32'h0000_0000, 0, 32'h0000_0077);
    vecs[5]  = mk(0, 1, 0, 4'b1111, 32'h0000_3000, 0, 5'd3,  32'h114, 32'h0000_0000, 0, 32'h0000_3000);
    vecs[6]  = mk(1, 0, 0, 4'b1111, 32'h0000_4000, 1, 5'd10, 32'h118, 32'h1234_5678, 1, 32'h1234_5678);
    vecs[7]  = mk(1, 0, 1, 4'b0011, 32'h0000_4000, 1, 5'd11, 32'h11C, 32'h0000_8001, 1, 32'hFFFF_8001);
    vecs[8]  = mk(1, 0, 0, 4'b0001, 32'h0000_4001, 1, 5'd12, 32'h120, 32'h0000_AB00, 1, 32'h0000_00AB);
    vecs[9]  = mk(1, 0, 0, 4'b0101, 32'h0000_4000, 1, 5'd13, 32'h124, 32'h1111_1111, 0, 32'h0000_0000);
    vecs[10] = mk(1, 0, 1, 4'b0011, 32'h0000_4003, 1, 5'd14, 32'h128, 32'h8000_8000, 0, 32'h0000_0000);
    vecs[11] = mk(1, 0, 0, 4'b1111, 32'h0000_4004, 1, 5'd0,  32'h12C, 32'h1234_5678, 0, 32'h1234_5678);

    v = mk(0, 0, 0, 4'b0000, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    drive(v);
    stall = 1'b0;
    flush = 1'b0;
    ram_read_data = 32'h0;
    rst_n = 1'b0;
`ifdef MEM_WB_RETIRE_CNT_EN
    exp_cnt = 32'd0;
    m_nb    = 1'b0;
`endif
    #12;
    check("reset_we",    {31'd0, reg_write_en}, 32'd0);
    check("reset_addr",  {27'd0, reg_write_addr}, 32'd0);
    check("reset_data",  reg_write_data, 32'd0);
    check("reset_pc",    current_pc_addr_out, 32'd0);
    check("reset_load",  {31'd0, wb_load_flag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      e.we = vecs[i].exp_we; e.waddr = vecs[i].waddr; e.data = vecs[i].exp_data;
      e.pc = vecs[i].pc;     e.load = vecs[i].rd;
      sb.push_back(e);
      tick();
      ram_read_data = vecs[i].ram;
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_we", i),   {31'd0, reg_write_en}, {31'd0, e.we});
      check($sformatf("vec%0d_addr", i), {27'd0, reg_write_addr}, {27'd0, e.waddr});
      check($sformatf("vec%0d_data", i), reg_write_data, e.data);
      check($sformatf("vec%0d_pc", i),   current_pc_addr_out, e.pc);
      check($sformatf("vec%0d_load", i), {31'd0, wb_load_flag}, {31'd0, e.load});
    end
`ifdef MEM_WB_RETIRE_CNT_EN
    check("retire_after_table", retire_cnt, exp_cnt);
`endif

    // Stall across a load: first stalled edge captures, then RAM data changes.
    drive(mk(1, 0, 0, 4'b1111, 32'h0000_5000, 1, 5'd11, 32'h300, 32'h0, 0, 32'h0));
    tick();
    ram_read_data = 32'h1111_2222;
    #1;
    check("stall_pre", reg_write_data, 32'h1111_2222);
    stall = 1'b1;
    drive(mk(0, 0, 0, 4'b0000, 32'h0000_1234, 1, 5'd9, 32'h304, 32'h0, 0, 32'h0));
    tick();
    check("stall_hold_valid", {31'd0, dut.r_hold_valid}, 32'd1);
    ram_read_data = 32'hDEAD_BEEF;
    #1;
    check("stall_c1_data", reg_write_data, 32'h1111_2222);
    tick();
    check("stall_c2_data", reg_write_data, 32'h1111_2222);
    check("stall_c2_pc",   current_pc_addr_out, 32'h300);
    tick();
    check("stall_c3_data", reg_write_data, 32'h1111_2222);
    stall = 1'b0;
    tick();
    check("release_data",       reg_write_data, 32'h0000_1234);
    check("release_addr",       {27'd0, reg_write_addr}, 32'd9);
    check("release_we",         {31'd0, reg_write_en}, 32'd1);
    check("release_hold_valid", {31'd0, dut.r_hold_valid}, 32'd0);

    // Flush and stall together: flush wins and the counter must not move.
`ifdef MEM_WB_RETIRE_CNT_EN
    cnt_before = retire_cnt;
`endif
    drive(mk(0, 0, 0, 4'b0000, 32'h0000_0055, 1, 5'd7, 32'h400, 32'h0, 0, 32'h0));
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("flush_we",   {31'd0, reg_write_en}, 32'd0);
    check("flush_pc",   current_pc_addr_out, 32'd0);
    check("flush_data", reg_write_data, 32'd0);
    check("flush_addr", {27'd0, reg_write_addr}, 32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
    check("flush_retire_same", retire_cnt, cnt_before);
    check("flush_retire_model", retire_cnt, exp_cnt);
`endif
    stall = 1'b0;
    flush = 1'b0;

    // Asynchronous reset while a load is held in WB.
    drive(mk(1, 0, 0, 4'b1111, 32'h0000_6000, 1, 5'd12, 32'h500, 32'h0, 0, 32'h0));
    tick();
    ram_read_data = 32'hA5A5_A5A5;
    stall = 1'b1;
    tick();
    check("rst_pre_hold_valid", {31'd0, dut.r_hold_valid}, 32'd1);
    check("rst_pre_we",         {31'd0, reg_write_en}, 32'd1);
    check("rst_pre_data",       reg_write_data, 32'hA5A5_A5A5);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_we",         {31'd0, reg_write_en}, 32'd0);
    check("rst_async_data",       reg_write_data, 32'd0);
    check("rst_async_hold_valid", {31'd0, dut.r_hold_valid}, 32'd0);
    check("rst_async_pc",         current_pc_addr_out, 32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
    exp_cnt = 32'd0;
    m_nb    = 1'b0;
    check("rst_async_retire", retire_cnt, exp_cnt);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
